// File: rtl/track_manager.sv
// Track manager: schedules up to four in-flight pairs through a rotating stage-tag ring.
// Optional illegal-command checking is enabled by defining TRACK_MGR_ERR_EN.
module track_manager #(
  parameter int unsigned NUM_TRACKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       do_add_track,
  input  logic       do_load,
  input  logic       do_compute,
  input  logic       do_sub_track,
  input  logic       done,
  input  logic [7:0] num_pairs,
  input  logic       pair_valid,
  output logic       pair_ready,
  output logic       track_avlbl,
  output logic       enter_new_pair,
  output logic       cmplt_sts,
  output logic [3:0] cur_ark2sb4_val,
  output logic [3:0] cur_mc2ark3_val,
  output logic [3:0] cur_mc2ark4_val,
  output logic [1:0] load_sel,
  output logic       out_valid,
  output logic [7:0] out_cnt,
  output logic       err
);

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INIT,
    CMD_SUB,
    CMD_ADD,
    CMD_LOAD,
    CMD_COMPUTE
  } cmd_e;

  localparam logic [2:0] MAX_ACTIVE = 3'(NUM_TRACKS);
  localparam logic [3:0] TAG_EMPTY  = 4'd15;
  localparam logic [3:0] TAG_LAST   = 4'd10;

  logic [3:0] st [4];
  logic [7:0] issued;
  logic [7:0] completed;
  logic [7:0] np_l;
  logic [2:0] active;
  cmd_e       cmd;

  always_comb begin
    cmd = CMD_NONE;
    if (init)              cmd = CMD_INIT;
    else if (do_sub_track) cmd = CMD_SUB;
    else if (do_add_track) cmd = CMD_ADD;
    else if (do_load)      cmd = CMD_LOAD;
    else if (do_compute)   cmd = CMD_COMPUTE;
  end

  assign track_avlbl     = (active < MAX_ACTIVE) && (issued < np_l);
  assign enter_new_pair  = track_avlbl && pair_valid && (st[3] == TAG_EMPTY) && do_compute;
  assign cmplt_sts       = (completed == np_l) && (active == '0);
  assign cur_ark2sb4_val = st[0];
  assign cur_mc2ark3_val = st[2];
  assign cur_mc2ark4_val = st[3];
  assign load_sel        = '0;
  assign out_cnt         = completed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) st[i] <= TAG_EMPTY;
      issued     <= '0;
      completed  <= '0;
      active     <= '0;
      np_l       <= '0;
      pair_ready <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      pair_ready <= 1'b0;
      out_valid  <= 1'b0;
      case (cmd)
        CMD_INIT: begin
          for (int unsigned i = 0; i < 4; i++) st[i] <= TAG_EMPTY;
          issued    <= '0;
          completed <= '0;
          active    <= '0;
          np_l      <= num_pairs;
        end
        CMD_SUB: begin
          if (st[2] == TAG_LAST) begin
            st[2]     <= TAG_EMPTY;
            out_valid <= 1'b1;
            if (active != '0)    active    <= active - 3'd1;
            if (completed != '1) completed <= completed + 8'd1;
          end
        end
        CMD_ADD: begin
          if (track_avlbl) begin
            issued <= issued + 8'd1;
            active <= active + 3'd1;
          end
        end
        CMD_LOAD: begin
          st[0]      <= '0;
          pair_ready <= 1'b1;
        end
        CMD_COMPUTE: begin
          // A tag gains one round only when it wraps from the last slot back to the first.
          st[1] <= st[0];
          st[2] <= st[1];
          st[3] <= st[2];
          st[0] <= (st[3] < TAG_LAST) ? st[3] + 4'd1 : st[3];
        end
        default: ;
      endcase
    end
  end

`ifdef TRACK_MGR_ERR_EN
  logic       err_q;
  logic       multi_cmd;
  logic       err_hit;

  assign multi_cmd = ({2'b0, do_add_track} + {2'b0, do_load} +
                      {2'b0, do_compute}   + {2'b0, do_sub_track}) > 3'd1;
  assign err_hit   = multi_cmd
                   | (do_add_track & ~track_avlbl)
                   | (do_load & (st[0] != TAG_EMPTY))
                   | (done & ~do_sub_track);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 1'b0;
    else if (init)    err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_done;
  assign unused_done = done;
  assign err = 1'b0;
`endif

endmodule

// File: doc/track_manager.md
TRACK_MANAGER -- requirements
Module: track_manager

Interface
REQ-001 The block SHALL have parameter NUM_TRACKS, default 4, giving the number of pipeline stage slots (tracks); only 4 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports init, do_add_track, do_load, do_compute, do_sub_track, done, input, 1 bit each: command strobes from the multi-run controller.
REQ-005 The block SHALL have port num_pairs, input, 8 bits: number of plaintext/key pairs in this run, sampled on init.
REQ-006 The block SHALL have port pair_valid, input, 1 bit: the host has a new pair ready.
REQ-007 The block SHALL have port pair_ready, output, 1 bit: one-cycle accept pulse for the host pair.
REQ-008 The block SHALL have ports track_avlbl, enter_new_pair and cmplt_sts, output, 1 bit each: status flags to the controller.
REQ-009 The block SHALL have ports cur_ark2sb4_val, cur_mc2ark3_val and cur_mc2ark4_val, output, 4 bits each: round tags of stage slots st[0], st[2] and st[3].
REQ-010 The block SHALL have port load_sel, output, 2 bits: slot index receiving the next load, fixed at 0.
REQ-011 The block SHALL have ports out_valid, output, 1 bit, and out_cnt, output, 8 bits: completion pulse and completed-pair count.
REQ-012 The block SHALL have port err, output, 1 bit: illegal-command flag (see Configuration).

Function
REQ-013 The block SHALL hold four 4-bit stage tags st[0..3], where value 15 means empty and values 0..10 are round numbers.
REQ-014 The block SHALL hold 8-bit counters issued and completed and a 3-bit counter active.
REQ-015 Command priority when several strobes are high SHALL be init > do_sub_track > do_add_track > do_load > do_compute; only the winner acts.
REQ-016 On init, the block SHALL set all st to 15, clear issued, completed and active to 0, and latch num_pairs.
REQ-017 On do_add_track, issued and active SHALL each increment by 1; if active==4 or issued==num_pairs, counters SHALL be unchanged.
REQ-018 On do_load, st[0] SHALL become 0, and pair_ready SHALL pulse for exactly that cycle.
REQ-019 On do_compute, the tags SHALL rotate: st[1]<=st[0], st[2]<=st[1], st[3]<=st[2], st[0]<=st[3]+1 if st[3] is in 0..9, st[3] if st[3] is 15 or 10.
REQ-020 On do_sub_track, the st[2] tag equal to 10 SHALL become 15, active SHALL decrement, completed SHALL increment, and out_valid SHALL pulse one cycle; if st[2]!=10 there SHALL be no effect.
REQ-021 A pulse on done SHALL be ignored functionally and SHALL be used only for the err check.
REQ-022 track_avlbl SHALL be combinational: (active<4) AND (issued<num_pairs_latched).
REQ-023 enter_new_pair SHALL be combinational: track_avlbl AND pair_valid AND (st[3]==15) AND do_compute, so that an empty slot rotates into st[0] next cycle.
REQ-024 cmplt_sts SHALL be combinational: (completed==num_pairs_latched) AND (active==0).
REQ-025 out_cnt SHALL equal completed.
REQ-026 Counters SHALL not wrap; num_pairs==0 SHALL give cmplt_sts=1 immediately after init.

Reset
REQ-027 While rst is low, all st SHALL be 15; issued, completed, active and latched num_pairs SHALL be 0; pair_ready, out_valid and err SHALL be 0.
REQ-028 Reset asserted mid-run SHALL abandon all tracks without producing out_valid.

Configuration
REQ-029 With TRACK_MGR_ERR_EN defined, err SHALL set sticky (cleared only by init or reset) on any of: more than one do_* strobe high; do_add_track with track_avlbl=0; do_load with st[0]!=15; done without do_sub_track.
REQ-030 Without TRACK_MGR_ERR_EN defined, err SHALL be constant 0 and no checking logic SHALL be synthesized.

Verification
REQ-031 Reset, then init with num_pairs=0 -> cmplt_sts=1, track_avlbl=0.
REQ-032 init with num_pairs=1, then add, load, then 42 computes -> st[2]==10 after the compute sequence; do_sub_track -> out_valid pulse, out_cnt=1, cmplt_sts=1.
REQ-033 init with num_pairs=6, fill 4 tracks -> track_avlbl=0; a fifth do_add_track -> counters unchanged, err=1 when TRACK_MGR_ERR_EN is defined.
REQ-034 do_compute with st[3]=15 while track_avlbl=1 and pair_valid=1 -> enter_new_pair=1 in that cycle; st[0]=15 next cycle.
REQ-035 do_sub_track and do_compute asserted together -> only the sub acts, no rotation; err=1 when TRACK_MGR_ERR_EN is defined.
REQ-036 rst pulsed low mid-run with 3 tracks active -> all tags read 15, out_cnt=0, no out_valid.
